// File: rtl/id_stage.sv
// Decode stage of the RV32I single-cycle core: owns the register file, builds the
// sign-extended immediate and decodes the main control signals from the opcode.
module id_stage #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [4:0]        rd,
    output logic [31:0]       imm_ext,
    output logic              reg_write,
    output logic              alu_src,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              branch,
    output logic              jump,
    output logic [1:0]        alu_op,
    output logic              illegal,
    output logic [31:0]       instret
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [DATA_W-1:0] regs [NREGS];
    logic [6:0]        opcode;
    logic [4:0]        rs1_idx;
    logic [4:0]        rs2_idx;
    logic              dec_reg_write;
    logic              dec_mem_read;
    logic              dec_mem_write;
    logic              dec_branch;
    logic              dec_jump;

    assign opcode  = instruction[6:0];
    assign rs1_idx = instruction[19:15];
    assign rs2_idx = instruction[24:20];
    assign rd      = instruction[11:7];

    // Reset wins over a write-back presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            instret <= '0;
        end else begin
            if (wb_we && wb_rd != 5'd0) regs[wb_rd] <= wb_data;
            if (!illegal) instret <= instret + 32'd1;
        end
    end

    always_comb begin
        rs1_data = '0;
        if (rs1_idx != 5'd0) begin
            rs1_data = regs[rs1_idx];
            if (BYPASS && rst && wb_we && wb_rd == rs1_idx) rs1_data = wb_data;
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_idx != 5'd0) begin
            rs2_data = regs[rs2_idx];
            if (BYPASS && rst && wb_we && wb_rd == rs2_idx) rs2_data = wb_data;
        end
    end

    always_comb begin
        imm_ext = 32'd0;
        case (opcode)
            OP_LOAD, OP_IALU, OP_JALR:
                imm_ext = {{20{instruction[31]}}, instruction[31:20]};
            OP_STORE:
                imm_ext = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            OP_BRANCH:
                imm_ext = {{19{instruction[31]}}, instruction[31], instruction[7],
                           instruction[30:25], instruction[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm_ext = {instruction[31:12], 12'd0};
            OP_JAL:
                imm_ext = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                           instruction[20], instruction[30:21], 1'b0};
            default:
                imm_ext = 32'd0;
        endcase
    end

    always_comb begin
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        alu_src       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_op        = 2'b00;
        illegal       = 1'b0;
        case (opcode)
            OP_R: begin
                dec_reg_write = 1'b1;
                alu_op        = 2'b10;
            end
            OP_IALU: begin
                dec_reg_write = 1'b1;
                alu_src       = 1'b1;
                alu_op        = 2'b11;
            end
            OP_LOAD: begin
                dec_reg_write = 1'b1;
                alu_src       = 1'b1;
                dec_mem_read  = 1'b1;
                mem_to_reg    = 1'b1;
            end
            OP_STORE: begin
                alu_src       = 1'b1;
                dec_mem_write = 1'b1;
            end
            OP_BRANCH: begin
                dec_branch = 1'b1;
                alu_op     = 2'b01;
            end
            OP_JAL: begin
                dec_jump      = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_JALR: begin
                dec_jump      = 1'b1;
                dec_reg_write = 1'b1;
                alu_src       = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec_reg_write = 1'b1;
                alu_src       = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Side-effecting enables are held off during reset so the core sees a NOP.
    assign reg_write = dec_reg_write & rst;
    assign mem_read  = dec_mem_read & rst;
    assign mem_write = dec_mem_write & rst;
    assign branch    = dec_branch & rst;
    assign jump      = dec_jump & rst;
endmodule

// File: tb/tb_id_stage.sv
// Randomized bench for id_stage, checked against a behavioural decode/register model.
module tb_id_stage;
    localparam bit BYPASS = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] rs1_data, rs2_data, imm_ext, instret;
    logic [4:0]  rd;
    logic        reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump, illegal;
    logic [1:0]  alu_op;
    logic [9:0]  act_ctrl;

    int total = 0;
    int bad = 0;

    logic [31:0] mregs [32];
    logic [31:0] minstret;
    logic [6:0]  legal_ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17};

    always #5 clk = ~clk;

    id_stage #(.DATA_W(32), .NREGS(32), .BYPASS(BYPASS)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd),
        .imm_ext(imm_ext), .reg_write(reg_write), .alu_src(alu_src), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump),
        .alu_op(alu_op), .illegal(illegal), .instret(instret)
    );

    assign act_ctrl = {reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump, alu_op, illegal};

    // Expected control: {reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump, alu_op[1:0], illegal}
    function automatic logic [9:0] m_ctrl(input logic [31:0] ins, input logic r);
        logic [9:0] c;
        case (ins[6:0])
            7'h33:        c = 10'b1000000_10_0;
            7'h13:        c = 10'b1100000_11_0;
            7'h03:        c = 10'b1110100_00_0;
            7'h23:        c = 10'b0101000_00_0;
            7'h63:        c = 10'b0000010_01_0;
            7'h6F:        c = 10'b1000001_00_0;
            7'h67:        c = 10'b1100001_00_0;
            7'h37, 7'h17: c = 10'b1100000_00_0;
            default:      c = 10'b0000000_00_1;
        endcase
        if (!r) c = c & 10'b0100100_11_1;
        return c;
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] i);
        logic signed [31:0] v;
        case (i[6:0])
            7'h03, 7'h13, 7'h67: v = 32'($signed(i[31:20]));
            7'h23:               v = 32'($signed({i[31:25], i[11:7]}));
            7'h63:               v = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            7'h37, 7'h17:        v = $signed({i[31:12], 12'd0});
            7'h6F:               v = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            default:             v = 0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (BYPASS && rst && wb_we && wb_rd == idx) return wb_data;
        return mregs[idx];
    endfunction

    function automatic logic [31:0] rand_inst(input bit allow_illegal);
        logic [31:0] r;
        r = $urandom();
        if (allow_illegal && $urandom_range(0, 5) == 0) return {r[31:7], 7'($urandom_range(0, 127))};
        return {r[31:7], legal_ops[$urandom_range(0, 8)]};
    endfunction

    task automatic apply(input logic r, input logic [31:0] ins, input logic we,
                         input logic [4:0] a, input logic [31:0] d);
        rst = r; instruction = ins; wb_we = we; wb_rd = a; wb_data = d;
        #2;
    endtask

    task automatic tick();
        logic [9:0] c;
        @(posedge clk);
        c = m_ctrl(instruction, 1'b1);
        if (!rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            minstret = 32'd0;
        end else begin
            if (wb_we && wb_rd != 5'd0) mregs[wb_rd] = wb_data;
            if (!c[0]) minstret = minstret + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply(1'b0, 32'h0002_8093, 1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        total++;
        if (act_ctrl !== m_ctrl(instruction, 1'b0)) begin
            bad++; $display("FAIL reset_gating got=%b exp=%b", act_ctrl, m_ctrl(instruction, 1'b0));
        end
        tick();
        apply(1'b1, 32'h0002_8093, 1'b0, 5'd0, 32'd0);
        total++;
        if (rs1_data !== 32'd0) begin bad++; $display("FAIL reset_x5 got=%h exp=0", rs1_data); end
        total++;
        if (instret !== 32'd0) begin bad++; $display("FAIL reset_instret got=%h exp=0", instret); end
    endtask

    task automatic test_write_read();
        apply(1'b1, 32'h0000_0013, 1'b1, 5'd3, 32'h1234_5678);
        tick();
        apply(1'b1, 32'h0031_00B3, 1'b0, 5'd0, 32'd0);
        total++;
        if (rs2_data !== 32'h1234_5678) begin bad++; $display("FAIL wr_rs2 got=%h exp=12345678", rs2_data); end
        total++;
        if (rs1_data !== 32'd0) begin bad++; $display("FAIL wr_rs1 got=%h exp=0", rs1_data); end
        total++;
        if (reg_write !== 1'b1 || alu_op !== 2'b10) begin
            bad++; $display("FAIL wr_ctrl got=%b/%b exp=1/10", reg_write, alu_op);
        end
        total++;
        if (rd !== 5'd1) begin bad++; $display("FAIL wr_rd got=%0d exp=1", rd); end
    endtask

    task automatic test_x0();
        apply(1'b1, 32'h0000_0013, 1'b1, 5'd0, 32'hFFFF_FFFF);
        total++;
        if (rs1_data !== 32'd0) begin bad++; $display("FAIL x0_same_cycle got=%h exp=0", rs1_data); end
        tick();
        apply(1'b1, 32'h0000_0013, 1'b0, 5'd0, 32'd0);
        total++;
        if (rs1_data !== 32'd0) begin bad++; $display("FAIL x0_after got=%h exp=0", rs1_data); end
    endtask

    task automatic test_bypass();
        apply(1'b1, 32'h0000_0013, 1'b1, 5'd7, 32'h11);
        tick();
        apply(1'b1, 32'h0003_8093, 1'b1, 5'd7, 32'h22);
        total++;
        if (rs1_data !== (BYPASS ? 32'h22 : 32'h11)) begin
            bad++; $display("FAIL bypass got=%h exp=%h", rs1_data, BYPASS ? 32'h22 : 32'h11);
        end
        tick();
        apply(1'b1, 32'h0003_8093, 1'b0, 5'd0, 32'd0);
        total++;
        if (rs1_data !== 32'h22) begin bad++; $display("FAIL bypass_after got=%h exp=22", rs1_data); end
    endtask

    task automatic test_immediates();
        apply(1'b1, 32'hFE00_0EE3, 1'b0, 5'd0, 32'd0);
        total++;
        if (imm_ext !== 32'hFFFF_FFFC || branch !== 1'b1) begin
            bad++; $display("FAIL imm_beq got=%h/%b exp=fffffffc/1", imm_ext, branch);
        end
        tick();
        apply(1'b1, 32'h0000_006F, 1'b0, 5'd0, 32'd0);
        total++;
        if (imm_ext !== 32'd0 || jump !== 1'b1) begin
            bad++; $display("FAIL imm_jal got=%h/%b exp=0/1", imm_ext, jump);
        end
        tick();
        apply(1'b1, 32'h1234_50B7, 1'b0, 5'd0, 32'd0);
        total++;
        if (imm_ext !== 32'h1234_5000) begin bad++; $display("FAIL imm_lui got=%h exp=12345000", imm_ext); end
        tick();
    endtask

    task automatic test_illegal_counter();
        apply(1'b0, 32'h0000_0013, 1'b0, 5'd0, 32'd0);
        tick();
        tick();
        for (int k = 0; k < 10; k++) begin
            apply(1'b1, rand_inst(1'b0), 1'b0, 5'd0, 32'd0);
            tick();
        end
        apply(1'b1, 32'h0000_0000, 1'b0, 5'd0, 32'd0);
        total++;
        if (act_ctrl !== 10'b0000000_00_1) begin
            bad++; $display("FAIL illegal_ctrl got=%b exp=0000000001", act_ctrl);
        end
        tick();
        apply(1'b1, 32'h0000_0013, 1'b0, 5'd0, 32'd0);
        total++;
        if (instret !== 32'd10) begin bad++; $display("FAIL instret_10 got=%0d exp=10", instret); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            apply(($urandom_range(0, 31) != 0), rand_inst(1'b1), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), $urandom());
            total++;
            if (rs1_data !== m_read(instruction[19:15])) begin
                bad++; $display("FAIL rnd_rs1 got=%h exp=%h", rs1_data, m_read(instruction[19:15]));
            end
            total++;
            if (rs2_data !== m_read(instruction[24:20])) begin
                bad++; $display("FAIL rnd_rs2 got=%h exp=%h", rs2_data, m_read(instruction[24:20]));
            end
            total++;
            if (imm_ext !== m_imm(instruction)) begin
                bad++; $display("FAIL rnd_imm inst=%h got=%h exp=%h", instruction, imm_ext, m_imm(instruction));
            end
            total++;
            if (act_ctrl !== m_ctrl(instruction, rst)) begin
                bad++; $display("FAIL rnd_ctrl inst=%h got=%b exp=%b", instruction, act_ctrl, m_ctrl(instruction, rst));
            end
            total++;
            if (rd !== instruction[11:7] || instret !== minstret) begin
                bad++; $display("FAIL rnd_rd_instret got=%0d/%h exp=%0d/%h", rd, instret, instruction[11:7], minstret);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        force dut.instret = 32'hFFFF_FFFE;
        #1;
        release dut.instret;
        minstret = 32'hFFFF_FFFE;
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, 32'h0000_0013, 1'b0, 5'd0, 32'd0);
            total++;
            if (instret !== minstret) begin bad++; $display("FAIL wrap_step got=%h exp=%h", instret, minstret); end
            tick();
        end
        apply(1'b1, 32'h0000_0013, 1'b0, 5'd0, 32'd0);
        total++;
        if (instret !== 32'd2) begin bad++; $display("FAIL wrap_final got=%h exp=2", instret); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        minstret = 32'd0;
        rst = 1'b0; instruction = 32'd0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_immediates();
        test_illegal_counter();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
